i2c_txn_arbiter: RTL and testbench

//  Round-robin arbiter and transaction sequencer that shares one I2C master among NUM_REQ

---
 rtl/i2c_txn_arbiter_if.sv | 31 +++
 rtl/i2c_txn_arbiter.sv | 143 ++++++++++++++
 tb/tb_i2c_txn_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_txn_arbiter_if.sv
// Bundle of requester-side and I2C-master-side signals around the arbiter.
interface i2c_txn_arbiter_if #(parameter int NUM_REQ = 2);
    // Requester side
    logic [NUM_REQ-1:0]   req;
    logic [7*NUM_REQ-1:0] req_addr;
    logic [NUM_REQ-1:0]   req_rw;
    logic [8*NUM_REQ-1:0] req_wdata;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ-1:0]   done;
    logic                 err;
    logic [7:0]           rdata;
    // I2C master side
    logic                 m_enable;
    logic [6:0]           m_addr;
    logic                 m_rw;
    logic [7:0]           m_wdata;
    logic                 m_ready;
    logic [7:0]           m_rdata;

    // Arbiter view
    modport slave (
        input  req, req_addr, req_rw, req_wdata, m_ready, m_rdata,
        output gnt, done, err, rdata, m_enable, m_addr, m_rw, m_wdata
    );

    // Environment view (requesters plus the I2C master)
    modport master (
        output req, req_addr, req_rw, req_wdata, m_ready, m_rdata,
        input  gnt, done, err, rdata, m_enable, m_addr, m_rw, m_wdata
    );
endinterface

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter sharing one I2C master among NUM_REQ requesters.
// One single-byte transaction per grant; launch and busy phases are each
// guarded by a timeout that completes the transaction with err=1.
module i2c_txn_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int LAUNCH_TO = 64,
    parameter int BUSY_TO   = 4096
) (
    input  logic              clk,
    input  logic              rst,
    i2c_txn_arbiter_if.slave  bus
);
    localparam int PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMAX = (LAUNCH_TO > BUSY_TO) ? LAUNCH_TO : BUSY_TO;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_BUSY, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [PW-1:0]      rr_q, rr_d;
    logic [PW-1:0]      g_q, g_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               err_q, err_d;
    logic [7:0]         rdata_q, rdata_d;
    logic [6:0]         addr_q, addr_d;
    logic               rw_q, rw_d;
    logic [7:0]         wdata_q, wdata_d;

    logic               sel_vld;
    logic [PW-1:0]      sel_idx;
    int                 cand;

    // Pick the first requester at or after rr_q, wrapping around.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        cand    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(rr_q) + i) % NUM_REQ;
            if (!sel_vld && bus.req[cand]) begin
                sel_vld = 1'b1;
                sel_idx = PW'(cand);
            end
        end
    end

    // Transaction sequencer: next state and next register values.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        rr_d    = rr_q;
        g_d     = g_q;
        gnt_d   = gnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                // A busy master is never handed a new transaction.
                if (sel_vld && bus.m_ready) begin
                    g_d     = sel_idx;
                    gnt_d   = NUM_REQ'(1) << sel_idx;
                    addr_d  = bus.req_addr[7*sel_idx +: 7];
                    rw_d    = bus.req_rw[sel_idx];
                    wdata_d = bus.req_wdata[8*sel_idx +: 8];
                    err_d   = 1'b0;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                timer_d = timer_q + TW'(1);
                if (!bus.m_ready) begin
                    timer_d = '0;
                    state_d = S_BUSY;
                end else if (timer_q == TW'(LAUNCH_TO - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_BUSY: begin
                timer_d = timer_q + TW'(1);
                if (bus.m_ready) begin
                    err_d   = 1'b0;
                    if (rw_q) rdata_d = bus.m_rdata;
                    state_d = S_DONE;
                end else if (timer_q == TW'(BUSY_TO - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Just-served requester drops to lowest priority.
                rr_d    = (g_q == PW'(NUM_REQ - 1)) ? '0 : g_q + PW'(1);
                gnt_d   = '0;
                timer_d = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any transaction silently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            rr_q    <= '0;
            g_q     <= '0;
            gnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            rr_q    <= rr_d;
            g_q     <= g_d;
            gnt_q   <= gnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.done     = (state_q == S_DONE) ? gnt_q : '0;
    assign bus.err      = (state_q == S_DONE) && err_q;
    assign bus.rdata    = rdata_q;
    // Enable is gated by ready so it falls in the very cycle the master
    // goes busy, leaving it exactly one transaction to run.
    assign bus.m_enable = (state_q == S_LAUNCH) && bus.m_ready;
    assign bus.m_addr   = addr_q;
    assign bus.m_rw     = rw_q;
    assign bus.m_wdata  = wdata_q;
endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Bench for i2c_txn_arbiter: behavioural I2C master model plus a done-side
// scoreboard fed by the stimulus tasks.
module tb_i2c_txn_arbiter;
    localparam int NR  = 2;
    localparam int LTO = 16;
    localparam int BTO = 100;

    typedef struct {
        int         idx;
        bit         err;
        bit         chk;
        logic [7:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    i2c_txn_arbiter_if #(.NUM_REQ(NR)) bus();

    i2c_txn_arbiter #(.NUM_REQ(NR), .LAUNCH_TO(LTO), .BUSY_TO(BTO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    // Master model controls: 0 normal, 1 never accepts, 2 stuck busy
    int         mode       = 0;
    int         busy_len   = 3;
    int         busy_cnt   = 0;
    logic [7:0] slave_byte = 8'h00;
    int         acc_cnt    = 0;
    logic [6:0] acc_addr;
    logic [7:0] acc_wdata;
    logic       acc_rw;

    // Master model, acting 2 time units after each rising edge
    initial begin
        bus.m_ready = 1'b1;
        bus.m_rdata = 8'h00;
        forever begin
            @(posedge clk);
            #2;
            if (!rst) begin
                bus.m_ready = 1'b1;
                busy_cnt    = 0;
            end else begin
                case (mode)
                    0: begin
                        if (bus.m_ready && bus.m_enable) begin
                            bus.m_ready = 1'b0;
                            acc_cnt++;
                            acc_addr  = bus.m_addr;
                            acc_wdata = bus.m_wdata;
                            acc_rw    = bus.m_rw;
                            busy_cnt  = busy_len;
                        end else if (!bus.m_ready) begin
                            if (busy_cnt == 0) begin
                                bus.m_rdata = slave_byte;
                                bus.m_ready = 1'b1;
                            end else begin
                                busy_cnt--;
                            end
                        end
                    end
                    1: bus.m_ready = 1'b1;
                    default: if (bus.m_ready && bus.m_enable) bus.m_ready = 1'b0;
                endcase
            end
        end
    end

    // Scoreboard and structural monitor
    initial begin
        exp_t          e;
        logic [NR-1:0] exp_done;
        forever begin
            @(negedge clk);
            if (rst) begin
                tests++;
                if ($countones(bus.gnt) > 1 || (bus.done & ~bus.gnt) != '0) begin
                    fails++;
                    $display("FAIL onehot: gnt=%b done=%b required one-hot gnt covering done", bus.gnt, bus.done);
                end
                if (|bus.done) begin
                    tests++;
                    if (sb.size() == 0) begin
                        fails++;
                        $display("FAIL sb_unexpected: done=%b required no done", bus.done);
                    end else begin
                        e        = sb.pop_front();
                        exp_done = NR'(1) << e.idx;
                        if (bus.done !== exp_done || bus.err !== e.err ||
                            (e.chk && bus.rdata !== e.rdata)) begin
                            fails++;
                            $display("FAIL sb_done: done=%b err=%b rdata=%h required done=%b err=%b rdata=%h",
                                     bus.done, bus.err, bus.rdata, exp_done, e.err, e.rdata);
                        end
                    end
                end
            end
        end
    end

    task automatic set_req(input int i, input logic [6:0] a, input logic rw, input logic [7:0] wd);
        bus.req_addr[7*i +: 7]  = a;
        bus.req_rw[i]           = rw;
        bus.req_wdata[8*i +: 8] = wd;
        bus.req[i]              = 1'b1;
    endtask

    task automatic push_exp(input int idx, input bit err, input bit chk, input logic [7:0] rd);
        exp_t e;
        e.idx = idx; e.err = err; e.chk = chk; e.rdata = rd;
        sb.push_back(e);
    endtask

    task automatic test_reset;
        bit seen = 0;
        int stray = 0;
        repeat (2) @(negedge clk);
        tests++;
        if (bus.gnt !== '0 || bus.done !== '0 || bus.err !== 1'b0 || bus.rdata !== 8'h00 ||
            bus.m_enable !== 1'b0 || bus.m_addr !== 7'h00 || bus.m_wdata !== 8'h00 || bus.m_rw !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: gnt=%b done=%b m_enable=%b m_addr=%h required all zero",
                     bus.gnt, bus.done, bus.m_enable, bus.m_addr);
        end
        rst = 1'b1;
        mode = 0; busy_len = 20;
        @(negedge clk);
        set_req(0, 7'h11, 1'b0, 8'h22);
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            if (bus.gnt == 2'b01 && bus.m_ready == 1'b0) seen = 1;
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL reset_reach_busy: busy=0 required 1");
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (bus.gnt !== '0 || bus.m_enable !== 1'b0 || bus.done !== '0) begin
            fails++;
            $display("FAIL reset_abort: gnt=%b m_enable=%b done=%b required 0 0 0",
                     bus.gnt, bus.m_enable, bus.done);
        end
        bus.req = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (bus.gnt != '0 || bus.done != '0) stray++;
        end
        tests++;
        if (stray != 0) begin
            fails++;
            $display("FAIL reset_idle: active cycles=%0d required 0", stray);
        end
    endtask

    task automatic test_single_write;
        int a0 = acc_cnt;
        int nd = 0;
        mode = 0; busy_len = 3;
        @(negedge clk);
        push_exp(0, 1'b0, 1'b0, 8'h00);
        set_req(0, 7'h50, 1'b0, 8'hA5);
        @(negedge clk);
        tests++;
        if (bus.gnt !== 2'b01) begin
            fails++;
            $display("FAIL write_grant: gnt=%b required 01", bus.gnt);
        end
        tests++;
        if (bus.m_addr !== 7'h50 || bus.m_wdata !== 8'hA5 || bus.m_rw !== 1'b0) begin
            fails++;
            $display("FAIL write_bus: addr=%h wdata=%h rw=%b required 50 a5 0", bus.m_addr, bus.m_wdata, bus.m_rw);
        end
        tests++;
        if (bus.m_ready !== 1'b0 || bus.m_enable !== 1'b0) begin
            fails++;
            $display("FAIL write_enable_drop: m_ready=%b m_enable=%b required 0 0", bus.m_ready, bus.m_enable);
        end
        repeat (30) begin
            @(negedge clk);
            if (bus.done[0]) begin
                nd++;
                tests++;
                if (bus.m_addr !== 7'h50 || bus.err !== 1'b0) begin
                    fails++;
                    $display("FAIL write_done_state: addr=%h err=%b required 50 0", bus.m_addr, bus.err);
                end
                bus.req[0] = 1'b0;
            end
        end
        tests++;
        if (nd != 1) begin
            fails++;
            $display("FAIL write_done_count: count=%0d required 1", nd);
        end
        tests++;
        if (acc_cnt - a0 != 1 || acc_addr !== 7'h50 || acc_wdata !== 8'hA5 || acc_rw !== 1'b0) begin
            fails++;
            $display("FAIL write_master_seen: txns=%0d addr=%h wdata=%h required 1 50 a5",
                     acc_cnt - a0, acc_addr, acc_wdata);
        end
    endtask

    task automatic test_read;
        bit seen = 0;
        mode = 0; busy_len = 4; slave_byte = 8'h5A;
        @(negedge clk);
        push_exp(1, 1'b0, 1'b1, 8'h5A);
        set_req(1, 7'h3C, 1'b1, 8'h00);
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (bus.done[1]) begin
                seen = 1;
                bus.req[1] = 1'b0;
                tests++;
                if (bus.rdata !== 8'h5A || bus.err !== 1'b0 || acc_addr !== 7'h3C || acc_rw !== 1'b1) begin
                    fails++;
                    $display("FAIL read_data: rdata=%h err=%b addr=%h required 5a 0 3c",
                             bus.rdata, bus.err, acc_addr);
                end
            end
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL read_timeout: done=0 required 1");
        end
    endtask

    task automatic test_round_robin;
        int order[$];
        int exp_order[4] = '{0, 1, 0, 1};
        mode = 0; busy_len = 2;
        @(negedge clk);
        foreach (exp_order[k]) push_exp(exp_order[k], 1'b0, 1'b0, 8'h00);
        set_req(0, 7'h21, 1'b0, 8'h01);
        set_req(1, 7'h22, 1'b0, 8'h02);
        for (int c = 0; c < 200 && order.size() < 4; c++) begin
            @(negedge clk);
            if (|bus.done) begin
                order.push_back(bus.done[1] ? 1 : 0);
                if (order.size() == 4) bus.req = '0;
            end
        end
        bus.req = '0;
        tests++;
        if (order.size() != 4) begin
            fails++;
            $display("FAIL rr_count: transactions=%0d required 4", order.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                tests++;
                if (order[k] != exp_order[k]) begin
                    fails++;
                    $display("FAIL rr_order[%0d]: granted=%0d required %0d", k, order[k], exp_order[k]);
                end
            end
        end
    endtask

    task automatic test_launch_timeout;
        int en = 0;
        bit seen = 0;
        mode = 1;
        @(negedge clk);
        push_exp(0, 1'b1, 1'b0, 8'h00);
        set_req(0, 7'h33, 1'b0, 8'h44);
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (bus.done[0]) begin
                seen = 1;
                bus.req[0] = 1'b0;
            end else if (bus.m_enable) begin
                en++;
            end
        end
        tests++;
        if (!seen || en != LTO) begin
            fails++;
            $display("FAIL launch_to: done=%b enable_cycles=%0d required 1 %0d", seen, en, LTO);
        end
        @(negedge clk);
        tests++;
        if (bus.m_enable !== 1'b0 || bus.gnt !== '0) begin
            fails++;
            $display("FAIL launch_to_after: m_enable=%b gnt=%b required 0 00", bus.m_enable, bus.gnt);
        end
        mode = 0;
    endtask

    task automatic test_busy_timeout;
        int bc = 0;
        bit seen = 0;
        mode = 2;
        @(negedge clk);
        push_exp(1, 1'b1, 1'b0, 8'h00);
        set_req(1, 7'h44, 1'b0, 8'h55);
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge clk);
            if (bus.done[1]) begin
                seen = 1;
                bus.req[1] = 1'b0;
            end else if (bus.gnt != '0 && !bus.m_ready) begin
                bc++;
            end
        end
        // One launch cycle (ready already low at its falling edge) plus BTO busy cycles
        tests++;
        if (!seen || bc != BTO + 1) begin
            fails++;
            $display("FAIL busy_to: done=%b busy_cycles=%0d required 1 %0d", seen, bc, BTO + 1);
        end
        busy_cnt = 0; mode = 0; busy_len = 2;
        repeat (3) @(negedge clk);
        push_exp(0, 1'b0, 1'b0, 8'h00);
        set_req(0, 7'h55, 1'b0, 8'h66);
        seen = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (bus.done[0]) begin
                seen = 1;
                bus.req[0] = 1'b0;
            end
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL busy_to_recover: done=0 required 1");
        end
    endtask

    initial begin
        bus.req = '0; bus.req_addr = '0; bus.req_rw = '0; bus.req_wdata = '0;
        test_reset();
        test_single_write();
        test_read();
        test_round_robin();
        test_launch_timeout();
        test_busy_timeout();
        repeat (5) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_leftover: pending=%0d required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
